// File: rtl/mod_segment_seq_if.sv
// Symbol, ROM and output-stream signals of mod_segment_seq.
// The master modport is the sequencer's view; slave is the surrounding logic.
// With MOD_SEGMENT_SEQ_NEG_SYM_EN defined, the symbol MSB is a polarity bit
// and does not take part in the ROM address.
interface mod_segment_seq_if #(
  parameter int DATA_W   = 32,
  parameter int SYM_BITS = 1,
  parameter int SEG_LEN  = 8
);
  localparam int CNT_W = $clog2(SEG_LEN);
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
  localparam int IDX_BITS = SYM_BITS - 1;
`else
  localparam int IDX_BITS = SYM_BITS;
`endif
  localparam int ADDR_W = IDX_BITS + CNT_W;

  logic                sym_valid;
  logic                sym_ready;
  logic [SYM_BITS-1:0] sym;
  logic                ref_rd;
  logic [ADDR_W-1:0]   ref_addr;
  logic [DATA_W-1:0]   ref_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [15:0]         sym_cnt;

  modport master (
    input  sym_valid, sym, ref_data, out_ready,
    output sym_ready, ref_rd, ref_addr, out_valid, out_data, out_last, sym_cnt
  );

  modport slave (
    output sym_valid, sym, ref_data, out_ready,
    input  sym_ready, ref_rd, ref_addr, out_valid, out_data, out_last, sym_cnt
  );
endinterface

// File: rtl/mod_segment_seq.sv
// Segment sequencer: turns each accepted symbol into SEG_LEN reads of a
// reference-waveform ROM (1-cycle latency) and streams the returned samples,
// tagged with a per-symbol last flag, through a 2-entry output FIFO.
// Reads are only issued when the FIFO is guaranteed room for the return, so
// the FIFO cannot overflow and backpressure stalls the ROM reads.
// Optional feature MOD_SEGMENT_SEQ_NEG_SYM_EN: antipodal mode where the symbol
// MSB negates (with saturation) every sample of that symbol.
module mod_segment_seq #(
  parameter int DATA_W   = 32,
  parameter int SYM_BITS = 1,
  parameter int SEG_LEN  = 8
) (
  input logic               clk,
  input logic               reset,
  mod_segment_seq_if.master bus
);
  localparam int CNT_W = $clog2(SEG_LEN);
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
  localparam int IDX_BITS = SYM_BITS - 1;
`else
  localparam int IDX_BITS = SYM_BITS;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nxt;
  logic [SYM_BITS-1:0]      sym_q;
  logic [CNT_W-1:0]         cnt;
  logic                     inflight;
  logic                     pend_last;
  logic [1:0][DATA_W-1:0]   fifo_data;
  logic [1:0]               fifo_last;
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               fifo_count;
  logic [15:0]              sym_cnt_q;
  logic                     pop, credit_ok, rd, last_rd, ready, accept;
  logic [2:0]               occupancy;
  logic [DATA_W-1:0]        wr_data;
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
  logic                     pend_neg;
`endif

  // Next-state, read strobe and symbol-ready decode from the current registers
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    ready     = 1'b0;
    pop       = (fifo_count != 2'd0) & bus.out_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    credit_ok = occupancy < 3'd2;
    last_rd   = (cnt == CNT_W'(SEG_LEN - 1));
    case (state)
      IDLE: begin
        ready = reset;
        if (bus.sym_valid && reset) state_nxt = RUN;
      end
      RUN: begin
        if (credit_ok) begin
          rd = 1'b1;
          if (last_rd) begin
            ready     = reset;
            state_nxt = bus.sym_valid ? RUN : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    accept = bus.sym_valid & ready;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Symbol latch, sample counter, read tracking and issued-symbol counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_q     <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      pend_last <= 1'b0;
      sym_cnt_q <= '0;
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
      pend_neg  <= 1'b0;
`endif
    end else begin
      inflight <= rd;
      if (rd) begin
        cnt       <= cnt + 1'b1;
        pend_last <= last_rd;
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
        pend_neg  <= sym_q[SYM_BITS-1];
`endif
        if (last_rd) sym_cnt_q <= sym_cnt_q + 16'd1;
      end
      if (accept) begin
        sym_q <= bus.sym;
        cnt   <= '0;
      end
    end
  end

  // Sample written into the FIFO, negated with saturation in antipodal mode
  always_comb begin
    wr_data = bus.ref_data;
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
    if (pend_neg) begin
      if (bus.ref_data == {1'b1, {(DATA_W-1){1'b0}}})
        wr_data = {1'b0, {(DATA_W-1){1'b1}}};
      else
        wr_data = {DATA_W{1'b0}} - bus.ref_data;
    end
`endif
  end

  // Two-entry output FIFO, written the cycle after each ROM read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_data  <= '0;
      fifo_last  <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= wr_data;
        fifo_last[wr_ptr] <= pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.sym_ready = ready;
  assign bus.ref_rd    = rd;
  assign bus.ref_addr  = {sym_q[IDX_BITS-1:0], cnt};
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid & fifo_last[rd_ptr];
  assign bus.sym_cnt   = sym_cnt_q;
endmodule

// File: tb/tb_mod_segment_seq.sv
// Directed bench for mod_segment_seq: reset state, single symbol latency,
// back-to-back symbols, output backpressure, mid-symbol reset and (when
// MOD_SEGMENT_SEQ_NEG_SYM_EN is defined) antipodal negation/saturation.
module tb_mod_segment_seq;
`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  logic        rom_mode = 1'b0;
  logic [31:0] rom_value = 32'd0;

  mod_segment_seq_if #(.DATA_W(32), .SYM_BITS(SB), .SEG_LEN(8)) bus ();

  mod_segment_seq #(.DATA_W(32), .SYM_BITS(SB), .SEG_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // ROM model: addr*3, or a fixed value when rom_mode is set; 1-cycle latency
  always @(posedge clk) begin
    if (bus.ref_rd) bus.ref_data <= rom_mode ? rom_value : 32'(bus.ref_addr) * 32'd3;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [SB-1:0] s, input logic ready);
    bus.sym_valid = valid;
    bus.sym       = s;
    bus.out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
    end
  endtask

  task automatic doReset;
    applyStimulus(1'b0, SB'(0), 1'b1);
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
  endtask

  initial begin
    int issued;
    int popped;
    int j;
    logic s;

    // ---------------- reset state ----------------
    applyStimulus(1'b0, SB'(0), 1'b1);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkBit("rst_sym_ready", bus.sym_ready, 1'b0);
    checkBit("rst_ref_rd", bus.ref_rd, 1'b0);
    checkBit("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkBit("rst_out_last", bus.out_last, 1'b0);
    checkOutput("rst_sym_cnt", 32'(bus.sym_cnt), 32'd0);
    tick;
    tick;
    reset = 1'b1;

    // ---------------- basic symbol ----------------
    $display("[TB] basic symbol");
    applyStimulus(1'b1, SB'(1), 1'b1);
    @(negedge clk);
    checkBit("basic_idle_ready", bus.sym_ready, 1'b1);
    tick;
    applyStimulus(1'b0, SB'(0), 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkBit("basic_ref_rd", bus.ref_rd, k <= 8);
      if (k <= 8) checkOutput("basic_ref_addr", 32'(bus.ref_addr), 32'(7 + k));
      checkBit("basic_sym_ready", bus.sym_ready, k >= 8);
      checkBit("basic_out_valid", bus.out_valid, k >= 3);
      if (k >= 3) begin
        checkOutput("basic_out_data", bus.out_data, 32'((5 + k) * 3));
        checkBit("basic_out_last", bus.out_last, k == 10);
      end
      tick;
    end
    @(negedge clk);
    checkBit("basic_drained", bus.out_valid, 1'b0);
    checkOutput("basic_sym_cnt", 32'(bus.sym_cnt), 32'd1);
    tick;

    // ---------------- back-to-back ----------------
    $display("[TB] back-to-back");
    doReset;
    for (int c = 0; c <= 27; c++) begin
      if (c == 0)       applyStimulus(1'b1, SB'(0), 1'b1);
      else if (c <= 8)  applyStimulus(1'b1, SB'(1), 1'b1);
      else if (c <= 16) applyStimulus(1'b1, SB'(0), 1'b1);
      else              applyStimulus(1'b0, SB'(0), 1'b1);
      @(negedge clk);
      if (c == 0 || c == 8 || c == 16) checkBit("b2b_ready_edge", bus.sym_ready, 1'b1);
      if (c == 5) checkBit("b2b_ready_mid", bus.sym_ready, 1'b0);
      if (c >= 3 && c <= 26) begin
        j = c - 3;
        s = ((j / 8) == 1);
        checkBit("b2b_out_valid", bus.out_valid, 1'b1);
        checkOutput("b2b_out_data", bus.out_data, 32'(((s ? 8 : 0) + (j % 8)) * 3));
        checkBit("b2b_out_last", bus.out_last, (j % 8) == 7);
      end else begin
        checkBit("b2b_out_idle", bus.out_valid, 1'b0);
      end
      tick;
    end
    @(negedge clk);
    checkOutput("b2b_sym_cnt", 32'(bus.sym_cnt), 32'd3);
    tick;

    // ---------------- backpressure ----------------
    $display("[TB] backpressure");
    doReset;
    issued = 0;
    popped = 0;
    for (int c = 0; c <= 30; c++) begin
      applyStimulus(c == 0, SB'(1), !(c >= 5 && c <= 9));
      @(negedge clk);
      if (bus.ref_rd) issued++;
      if (bus.out_valid && bus.out_ready) begin
        if (popped < 8) begin
          checkOutput("bp_order_data", bus.out_data, 32'((8 + popped) * 3));
          checkBit("bp_order_last", bus.out_last, popped == 7);
        end else begin
          checkOutput("bp_extra_pop", 32'(popped), 32'd7);
        end
        popped++;
      end
      checkBit("bp_no_overflow", (issued - popped) <= 2, 1'b1);
      if (c >= 5 && c <= 9) begin
        checkBit("bp_stall_rd", bus.ref_rd, 1'b0);
        checkBit("bp_hold_valid", bus.out_valid, 1'b1);
        checkOutput("bp_hold_data", bus.out_data, 32'd30);
      end
      if (c == 10) begin
        checkBit("bp_resume_rd", bus.ref_rd, 1'b1);
        checkOutput("bp_resume_addr", 32'(bus.ref_addr), 32'd12);
      end
      tick;
    end
    checkOutput("bp_pop_count", 32'(popped), 32'd8);
    checkOutput("bp_sym_cnt", 32'(bus.sym_cnt), 32'd1);

    // ---------------- reset mid-operation ----------------
    $display("[TB] reset mid-symbol");
    applyStimulus(1'b1, SB'(1), 1'b1);
    tick;
    applyStimulus(1'b0, SB'(0), 1'b1);
    for (int c = 1; c < 5; c++) tick;
    reset = 1'b0;
    #1;
    checkBit("mid_rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("mid_rst_out_data", bus.out_data, 32'd0);
    checkBit("mid_rst_out_last", bus.out_last, 1'b0);
    checkOutput("mid_rst_sym_cnt", 32'(bus.sym_cnt), 32'd0);
    checkBit("mid_rst_ref_rd", bus.ref_rd, 1'b0);
    checkBit("mid_rst_ready", bus.sym_ready, 1'b0);
    tick;
    tick;
    reset = 1'b1;
    applyStimulus(1'b1, SB'(1), 1'b1);
    tick;
    applyStimulus(1'b0, SB'(0), 1'b1);
    @(negedge clk);
    checkBit("post_rst_rd", bus.ref_rd, 1'b1);
    checkOutput("post_rst_addr", 32'(bus.ref_addr), 32'd8);
    checkBit("post_rst_no_stale1", bus.out_valid, 1'b0);
    tick;
    @(negedge clk);
    checkBit("post_rst_no_stale2", bus.out_valid, 1'b0);
    tick;
    @(negedge clk);
    checkBit("post_rst_valid", bus.out_valid, 1'b1);
    checkOutput("post_rst_data", bus.out_data, 32'd24);
    for (int c = 0; c < 10; c++) tick;
    @(negedge clk);
    checkOutput("post_rst_sym_cnt", 32'(bus.sym_cnt), 32'd1);
    tick;

`ifdef MOD_SEGMENT_SEQ_NEG_SYM_EN
    // ---------------- antipodal mode ----------------
    $display("[TB] antipodal");
    doReset;
    rom_mode  = 1'b1;
    rom_value = 32'd100;
    applyStimulus(1'b1, SB'(3), 1'b1);
    tick;
    applyStimulus(1'b0, SB'(0), 1'b1);
    @(negedge clk);
    checkOutput("neg_addr", 32'(bus.ref_addr), 32'd8);
    tick;
    tick;
    @(negedge clk);
    checkBit("neg_valid", bus.out_valid, 1'b1);
    checkOutput("neg_data", bus.out_data, 32'hFFFF_FF9C);
    for (int c = 0; c < 10; c++) tick;
    rom_value = 32'h8000_0000;
    applyStimulus(1'b1, SB'(2), 1'b1);
    tick;
    applyStimulus(1'b0, SB'(0), 1'b1);
    @(negedge clk);
    checkOutput("sat_addr", 32'(bus.ref_addr), 32'd0);
    tick;
    tick;
    @(negedge clk);
    checkOutput("sat_data", bus.out_data, 32'h7FFF_FFFF);
    for (int c = 0; c < 10; c++) tick;
    applyStimulus(1'b1, SB'(1), 1'b1);
    tick;
    applyStimulus(1'b0, SB'(0), 1'b1);
    tick;
    tick;
    @(negedge clk);
    checkOutput("pos_data", bus.out_data, 32'h8000_0000);
    for (int c = 0; c < 10; c++) tick;
    rom_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
